// File: rtl/watch_pkg.sv
// Shared definitions for the watch front-end button path.
package watch_pkg;

   // Per-channel click classifier state encoding.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } click_state_t;

   // 100 MHz clock divided down to a 1 ms timebase tick.
   localparam int TICK_DIV_1MS   = 100_000;
   // Default double-click window, in timebase ticks.
   localparam int DBL_MS_DEFAULT = 300;

endpackage

// File: rtl/click_fsm.sv
// One button channel: classifies debounced press pulses as single or double clicks.
// The window opens on a press and spans DBL_MS timebase ticks; a second press
// inside it (including on the expiring tick) makes a double, expiry makes a single.
module click_fsm
   import watch_pkg::*;
#(
   parameter int DBL_MS = DBL_MS_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick,
   input  logic         pulse,
   output logic         single,
   output logic         double,
   output logic         busy,
   output click_state_t state_dbg
);

   localparam int                WIN_W    = $clog2(DBL_MS);
   localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(DBL_MS - 1);

   click_state_t     state;
   logic [WIN_W-1:0] win_cnt;

   // Window FSM with registered single/double strobes; a press always beats expiry.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= ST_IDLE;
         win_cnt <= '0;
         single  <= 1'b0;
         double  <= 1'b0;
      end else begin
         single <= 1'b0;
         double <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pulse) begin
                  state   <= ST_WAIT;
                  win_cnt <= '0;
               end
            end
            ST_WAIT: begin
               if (pulse) begin
                  double  <= 1'b1;
                  state   <= ST_IDLE;
                  win_cnt <= '0;
               end else if (tick) begin
                  if (win_cnt == WIN_LAST) begin
                     single <= 1'b1;
                     state  <= ST_IDLE;
                  end else begin
                     win_cnt <= win_cnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign busy      = (state == ST_WAIT);
   assign state_dbg = state;

endmodule

// File: rtl/btn_click_classifier.sv
// Click classifier for all buttons: one shared free-running timebase feeding
// an independent click_fsm per button.
//
// Output contract: o_single/o_double are one-cycle strobes with no back-pressure;
// the consumer must accept them in the cycle they are high. o_busy is a level.
// dbg_state[k] mirrors channel k's FSM state (1 = waiting inside the window).
module btn_click_classifier
   import watch_pkg::*;
#(
   parameter int N_BTN    = 3,
   parameter int TICK_DIV = TICK_DIV_1MS,
   parameter int DBL_MS   = DBL_MS_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] i_btn_pulse,
   output logic [N_BTN-1:0] o_single,
   output logic [N_BTN-1:0] o_double,
   output logic [N_BTN-1:0] o_busy,
   output logic [N_BTN-1:0] dbg_state
);

   localparam int             TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0]  TICK_TOP = TW'(TICK_DIV - 1);

   logic [TW-1:0] tick_cnt;
   logic          tick;
   click_state_t  ch_state [N_BTN];

   assign tick = (tick_cnt == TICK_TOP);

   // Free-running timebase; presses never re-phase it, only reset does.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   for (genvar k = 0; k < N_BTN; k++) begin : g_ch
      click_fsm #(
         .DBL_MS (DBL_MS)
      ) u_click_fsm (
         .clk       (clk),
         .rst       (rst),
         .tick      (tick),
         .pulse     (i_btn_pulse[k]),
         .single    (o_single[k]),
         .double    (o_double[k]),
         .busy      (o_busy[k]),
         .state_dbg (ch_state[k])
      );
      assign dbg_state[k] = ch_state[k];
   end

endmodule

// File: tb/tb_btn_click_classifier.sv
// Bench for btn_click_classifier with a small timebase (TICK_DIV=4, DBL_MS=3).
// Stimulus pushes expected output events {edge, channel, kind} into exp_q;
// a negedge monitor matches every observed strobe against that queue.
module tb_btn_click_classifier;

   localparam int N_BTN    = 3;
   localparam int TICK_DIV = 4;
   localparam int DBL_MS   = 3;
   localparam int W        = 19;

   logic             clk = 1'b0;
   logic             rst;
   logic [N_BTN-1:0] i_btn_pulse;
   logic [N_BTN-1:0] o_single;
   logic [N_BTN-1:0] o_double;
   logic [N_BTN-1:0] o_busy;
   logic [N_BTN-1:0] dbg_state;

   int n_tests  = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_rst = 0;

   logic [W-1:0] exp_q[$];

   btn_click_classifier #(
      .N_BTN    (N_BTN),
      .TICK_DIV (TICK_DIV),
      .DBL_MS   (DBL_MS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_btn_pulse (i_btn_pulse),
      .o_single    (o_single),
      .o_double    (o_double),
      .o_busy      (o_busy),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / edge counter ----------------
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- helpers ----------------
   function automatic logic [W-1:0] mk_ev(int edge_n, int ch, int kind);
      logic [15:0] e16;
      logic [1:0]  c2;
      e16 = 16'(edge_n);
      c2  = 2'(ch);
      return {e16, c2, kind[0]};
   endfunction

   // Edge at which a single is due for a first press sampled at edge p:
   // the DBL_MS-th tick edge strictly after p. Ticks land on edges
   // last_rst + TICK_DIV*m (m >= 1).
   function automatic int single_edge(int p);
      int e;
      e = p;
      for (int t = 0; t < DBL_MS; t++) begin
         e++;
         while (((e - last_rst) % TICK_DIV) != 0) e++;
      end
      return e;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until edge n has just been taken.
   task automatic goto_after(int n);
      while (cyc < n) step();
   endtask

   // Press mask so that it is sampled at edge n.
   task automatic press_at(int n, logic [N_BTN-1:0] mask);
      goto_after(n - 1);
      i_btn_pulse = mask;
      step();
      i_btn_pulse = '0;
   endtask

   // ---------------- monitor / scoreboard ----------------
   task automatic match_event(int ch, int kind);
      logic [W-1:0] ev;
      int idx;
      ev  = mk_ev(cyc, ch, kind);
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i] == ev && idx < 0) idx = i;
      end
      n_tests++;
      if (idx < 0) begin
         n_fail++;
         $display("FAIL event ch%0d %s @edge %0d: got pulse, want none", ch,
                  (kind == 1) ? "double" : "single", cyc);
      end else begin
         exp_q.delete(idx);
      end
   endtask

   always @(negedge clk) begin
      if (cyc >= 1) begin
         for (int k = 0; k < N_BTN; k++) begin
            if (o_single[k] === 1'b1) match_event(k, 0);
            if (o_double[k] === 1'b1) match_event(k, 1);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst         = 1'b0;
      i_btn_pulse = 3'b111;

      // Reset held for edges 1..3 with all buttons pressed.
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_single", 32'(o_single), 32'd0);
         check("rst_double", 32'(o_double), 32'd0);
         check("rst_busy",   32'(o_busy),   32'd0);
      end
      rst         = 1'b1;
      i_btn_pulse = '0;
      last_rst    = 3;
      step();
      check("post_rst_single", 32'(o_single), 32'd0);
      check("post_rst_double", 32'(o_double), 32'd0);
      check("post_rst_busy",   32'(o_busy),   32'd0);

      // Single click on bit0: ticks at 11,15,19 -> single at 19.
      exp_q.push_back(mk_ev(single_edge(10), 0, 0));
      press_at(10, 3'b001);
      check("single_busy_rise", 32'(o_busy[0]), 32'd1);
      check("single_dbg_state", 32'(dbg_state[0]), 32'd1);
      goto_after(18);
      check("single_busy_hold", 32'(o_busy[0]), 32'd1);
      goto_after(19);
      check("single_busy_fall", 32'(o_busy[0]), 32'd0);

      // Double click on bit1: presses at 25 and 30 -> double at 30.
      exp_q.push_back(mk_ev(30, 1, 1));
      press_at(25, 3'b010);
      check("double_busy_rise", 32'(o_busy[1]), 32'd1);
      press_at(30, 3'b010);
      check("double_busy_fall", 32'(o_busy[1]), 32'd0);

      // Collision: bit2 at 40, ticks 43,47,51; second press on 51 -> double only.
      exp_q.push_back(mk_ev(51, 2, 1));
      press_at(40, 3'b100);
      press_at(51, 3'b100);
      check("collide_busy_fall", 32'(o_busy[2]), 32'd0);

      // Independence: 3'b101 at 60, bit2 again at 64.
      exp_q.push_back(mk_ev(64, 2, 1));
      exp_q.push_back(mk_ev(single_edge(60), 0, 0));
      press_at(60, 3'b101);
      check("indep_busy", 32'(o_busy), 32'b101);
      press_at(64, 3'b100);
      check("indep_busy_after", 32'(o_busy), 32'b001);

      // Third press right after a double opens a fresh window (single at 95).
      exp_q.push_back(mk_ev(82, 1, 1));
      exp_q.push_back(mk_ev(single_edge(83), 1, 0));
      press_at(80, 3'b010);
      press_at(82, 3'b010);
      press_at(83, 3'b010);
      check("third_busy", 32'(o_busy[1]), 32'd1);

      // Reset mid-window: press at 100, reset sampled at 105, nothing emitted.
      press_at(100, 3'b001);
      goto_after(104);
      rst = 1'b0;
      step();
      rst      = 1'b1;
      last_rst = 105;
      check("midrst_busy", 32'(o_busy), 32'd0);
      goto_after(109);
      check("midrst_busy_later", 32'(o_busy[0]), 32'd0);

      // Timebase re-phased by reset: ticks at 109,113,117,121 -> single at 121.
      exp_q.push_back(mk_ev(single_edge(110), 0, 0));
      press_at(110, 3'b001);

      // Level held two cycles on bit2 behaves as two presses -> double at 126.
      exp_q.push_back(mk_ev(126, 2, 1));
      goto_after(124);
      i_btn_pulse = 3'b100;
      step();
      step();
      i_btn_pulse = '0;

      goto_after(140);
      check("pending_events", 32'(exp_q.size()), 32'd0);
      foreach (exp_q[i])
         $display("FAIL missing event edge %0d ch%0d kind %0d: got none, want pulse",
                  exp_q[i][W-1:3], exp_q[i][2:1], exp_q[i][0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
